i2s_serializer: RTL and testbench

Stereo I2S transmitter that serializes 16-bit left/right PCM samples onto `i2s_data`, MSB first with the standard one-BCLK delay after each LRCLK transition. It consumes `i2s_bclk` and `i2s_lrclk` from `audio_timing`, which runs in the same clock domain. It takes samples from the sound mixer through a one-deep valid/ready holding register, and reports underruns and framing errors.

---
 rtl/i2s_serializer_if.sv | 9 +
 rtl/i2s_serializer.sv | 72 +++++++
 tb/tb_i2s_serializer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_serializer_if.sv
// i2s_serializer_if: sample-pair valid/ready handshake between the mixer and the I2S transmitter
interface i2s_serializer_if #(parameter int BITS = 16);
  logic [BITS-1:0] sample_left;
  logic [BITS-1:0] sample_right;
  logic            sample_valid;
  logic            sample_ready;
  modport master(output sample_left, sample_right, sample_valid, input sample_ready);
  modport slave(input sample_left, sample_right, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_serializer.sv
// i2s_serializer: stereo I2S transmitter, MSB first with one-BCLK delay, fed through a one-deep holding register
module i2s_serializer #(
  parameter int BITS            = 16,
  parameter bit UNDERRUN_REPEAT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  i2s_serializer_if.slave smp,
  input  logic            i2s_bclk,
  input  logic            i2s_lrclk,
  output logic            i2s_data,
  output logic            underrun,
  output logic            sync_error
);
  localparam int CW = $clog2(BITS + 2);
  logic            bclk_q, lr_q, armed, hold_full;
  logic [CW-1:0]   bit_cnt;
  logic [BITS-1:0] shreg, act_l, act_r, hold_l, hold_r, new_l, new_r;
  logic            fall, bnd, accept;
  always_comb begin
    fall   = bclk_q & ~i2s_bclk;
    bnd    = fall & (i2s_lrclk != lr_q);
    accept = smp.sample_valid & ~hold_full;
    new_l  = hold_full ? hold_l : UNDERRUN_REPEAT ? act_l : '0;
    new_r  = hold_full ? hold_r : UNDERRUN_REPEAT ? act_r : '0;
  end
  assign smp.sample_ready = ~hold_full;
  // the left word loads from the frame being latched this cycle, so L and R always share a frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bclk_q     <= 1'b0;
      lr_q       <= 1'b0;
      armed      <= 1'b0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      act_l      <= '0;
      act_r      <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      i2s_data   <= 1'b0;
      underrun   <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      bclk_q     <= i2s_bclk;
      underrun   <= 1'b0;
      sync_error <= 1'b0;
      if (accept) begin
        hold_l    <= smp.sample_left;
        hold_r    <= smp.sample_right;
        hold_full <= 1'b1;
      end
      if (fall) begin
        lr_q     <= i2s_lrclk;
        i2s_data <= shreg[BITS-1];
        shreg    <= shreg << 1;
        bit_cnt  <= (bit_cnt == CW'(BITS + 1)) ? bit_cnt : bit_cnt + 1'b1;
      end
      if (bnd) begin
        bit_cnt    <= CW'(1);
        armed      <= 1'b1;
        sync_error <= armed & (bit_cnt != CW'(BITS));
        shreg      <= i2s_lrclk ? act_r : new_l;
      end
      if (bnd & ~i2s_lrclk) begin
        act_l    <= new_l;
        act_r    <= new_r;
        underrun <= ~hold_full;
        if (hold_full) hold_full <= 1'b0;
      end
    end
endmodule

// File: tb/tb_i2s_serializer.sv
// tb_i2s_serializer: randomized and directed checks of both underrun policies against a frame-level model
module tb_i2s_serializer;
  localparam int BITS = 16;
  logic clk = 1'b0, reset = 1'b1, bclk = 1'b0, lrclk = 1'b0, sv = 1'b0;
  logic [15:0] sl = '0, sr = '0, os_l = '0, os_r = '0;
  wire [1:0] dat, ur, se, rdy;
  i2s_serializer_if #(.BITS(BITS)) sif0 ();
  i2s_serializer_if #(.BITS(BITS)) sif1 ();
  assign sif0.sample_left = sl;
  assign sif0.sample_right = sr;
  assign sif0.sample_valid = sv;
  assign sif1.sample_left = sl;
  assign sif1.sample_right = sr;
  assign sif1.sample_valid = sv;
  assign rdy = {sif1.sample_ready, sif0.sample_ready};
  i2s_serializer #(.BITS(BITS), .UNDERRUN_REPEAT(1'b0)) u0 (
    .clk(clk), .reset(reset), .smp(sif0), .i2s_bclk(bclk), .i2s_lrclk(lrclk),
    .i2s_data(dat[0]), .underrun(ur[0]), .sync_error(se[0]));
  i2s_serializer #(.BITS(BITS), .UNDERRUN_REPEAT(1'b1)) u1 (
    .clk(clk), .reset(reset), .smp(sif1), .i2s_bclk(bclk), .i2s_lrclk(lrclk),
    .i2s_data(dat[1]), .underrun(ur[1]), .sync_error(se[1]));
  initial forever #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // timing generator and sample source share one process so a source can react to the boundary it drives
  int ph = 0, nb = 0, half_len = 16, mode = 0, rx_skip = 0;
  bit short_req = 0, lb_now = 0, acc_flag = 0;
  logic [15:0] bp_cnt = 16'd1;
  initial forever begin
    @(negedge clk);
    lb_now = 0;
    ph++;
    if (ph == 8) bclk = 1'b1;
    if (ph == 16) begin
      ph = 0;
      bclk = 1'b0;
      nb++;
      if (nb == half_len) begin
        nb = 0;
        lrclk = ~lrclk;
        lb_now = ~lrclk;
        half_len = short_req ? 15 : 16;
        if (short_req) rx_skip = 2;
        short_req = 0;
      end
    end
    case (mode)
      1: begin sv = 1'b1; sl = 16'hCAFE; sr = 16'hBABE; end
      2: begin
        if (acc_flag) bp_cnt++;
        sv = 1'b1; sl = bp_cnt; sr = 16'h8000 | bp_cnt;
      end
      3: if (!sv || acc_flag) begin
        sv = ($urandom_range(0, 299) == 0);
        sl = 16'($urandom);
        sr = 16'($urandom);
      end
      4: if (acc_flag && sv) begin sv = 1'b0; mode = 0; end
         else begin sv = 1'b1; sl = os_l; sr = os_r; end
      5: begin sv = lb_now; sl = os_l; sr = os_r; if (lb_now) mode = 0; end
      default: sv = 1'b0;
    endcase
  end
  // frame-level reference: pending pair, current frame per policy, expected word stream, bit counts
  bit m_bq = 0, m_lr = 0, m_armed = 0, pend = 0, was_pend = 0, exp_ur = 0, exp_se = 0;
  bit rx_bq = 0, rx_lr = 0, bp_mode = 0;
  int nf = 0, bp_acc = 0, wh[2], wt[2], se_cnt[2];
  longint cyc = 0, last_acc = 0;
  logic [15:0] h_l = '0, h_r = '0, act_l[2], act_r[2], rx[2], wq[2][64];
  initial begin
    for (int k = 0; k < 2; k++) begin
      act_l[k] = '0; act_r[k] = '0; rx[k] = '0; wh[k] = 0; wt[k] = 0; se_cnt[k] = 0;
    end
  end
  initial forever begin
    @(posedge clk);
    cyc++;
    exp_ur = 0;
    exp_se = 0;
    acc_flag = 0;
    if (reset) begin
      m_bq = 0; m_lr = 0; m_armed = 0; pend = 0; nf = 0;
      for (int k = 0; k < 2; k++) begin act_l[k] = '0; act_r[k] = '0; wh[k] = 0; wt[k] = 0; end
    end else begin
      was_pend = pend;
      if (m_bq && !bclk) begin
        nf++;
        if (lrclk != m_lr) begin
          exp_se = m_armed && (nf != BITS);
          m_armed = 1;
          nf = 0;
          if (!lrclk) begin
            if (was_pend) pend = 0;
            else exp_ur = 1;
          end
          for (int k = 0; k < 2; k++) begin
            if (!lrclk) begin
              if (was_pend) begin act_l[k] = h_l; act_r[k] = h_r; end
              else if (k == 0) begin act_l[k] = '0; act_r[k] = '0; end
            end
            wq[k][wt[k] % 64] = lrclk ? act_r[k] : act_l[k];
            wt[k]++;
          end
        end
        m_lr = lrclk;
      end
      m_bq = bclk;
      if (sv && !was_pend) begin
        h_l = sl; h_r = sr; pend = 1; acc_flag = 1;
        if (bp_mode) begin
          bp_acc++;
          if (bp_acc >= 3) chk("acc_gap", 32'(cyc - last_acc), 32'd512);
          last_acc = cyc;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ready", 32'(rdy[k]), 32'(!pend));
      chk("underrun", 32'(ur[k]), 32'(exp_ur));
      chk("sync_error", 32'(se[k]), 32'(exp_se));
      se_cnt[k] += 32'(se[k]);
    end
    if (!rx_bq && bclk) begin
      for (int k = 0; k < 2; k++) rx[k] = {rx[k][14:0], dat[k]};
      if (lrclk != rx_lr) begin
        for (int k = 0; k < 2; k++)
          if (wt[k] - wh[k] >= 2) begin
            if (rx_skip != 1) chk(k == 0 ? "word_zero" : "word_repeat", 32'(rx[k]), 32'(wq[k][wh[k] % 64]));
            wh[k]++;
          end
        if (rx_skip > 0) rx_skip--;
        rx_lr = lrclk;
      end
    end
    rx_bq = bclk;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end
  int snap[2];
  initial begin
    mode = 1;
    repeat (5) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_data", 32'(dat[k]), 32'd0);
      chk("rst_ready", 32'(rdy[k]), 32'd1);
    end
    mode = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mode = 1;
    repeat (8 * 512) @(negedge clk);
    bp_acc = 0;
    bp_mode = 1;
    mode = 2;
    repeat (8 * 512) @(negedge clk);
    bp_mode = 0;
    mode = 3;
    repeat (20 * 512) @(negedge clk);
    mode = 0;
    sv = 1'b0;
    repeat (2 * 512) @(negedge clk);
    os_l = 16'h1234; os_r = 16'h5678; mode = 4;
    repeat (4 * 512) @(negedge clk);
    os_l = 16'($urandom); os_r = 16'($urandom); mode = 5;
    repeat (3 * 512) @(negedge clk);
    os_l = 16'hFFFF; os_r = 16'hFFFF; mode = 4;
    for (int i = 0; i < 2000 && mode != 0; i++) @(negedge clk);
    chk("oneshot_accepted", 32'(mode), 32'd0);
    @(negedge lrclk);
    repeat (150) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("pre_rst_bit7", 32'(dat[k]), 32'd1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("rst_async_data", 32'(dat[k]), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk("post_rst_ready", 32'(rdy[k]), 32'd1);
    repeat (2 * 512) @(negedge clk);
    mode = 1;
    repeat (2 * 512) @(negedge clk);
    for (int k = 0; k < 2; k++) snap[k] = se_cnt[k];
    short_req = 1;
    repeat (3 * 512) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("misframe_pulses", 32'(se_cnt[k] - snap[k]), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
